// File: rtl/multicycle_sequencer_if.sv
// Control/status bundle between the multicycle sequencer and the MIPS datapath.
// master = sequencer (drives selects/enables), slave = datapath side.
interface multicycle_sequencer_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] state;
    logic       halted;
    logic       illegal_op;
    logic       bus_error;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               state, halted, illegal_op, bus_error
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               state, halted, illegal_op, bus_error
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over one shared memory port, with a memory-wait watchdog that halts on timeout.
module multicycle_sequencer #(
    parameter int unsigned MEM_WAIT_LIMIT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        WB_MEM   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        WB_R     = 4'd7,
        EXEC_I   = 4'd8,
        WB_I     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] wait_q;
    logic [5:0] op_q;
    logic       illegal_q, bus_err_q;
    logic       wait_state, timeout, decode_bad;

    assign wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout    = wait_state && !bus.mem_ready && (wait_q == WAIT_LIMIT);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        decode_bad = 1'b0;
        case (state_q)
            FETCH:  if (bus.mem_ready) state_d = DECODE;
                    else if (timeout)  state_d = HALT;
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:       state_d = EXEC_R;
                    OP_ADDI:        state_d = EXEC_I;
                    OP_LW, OP_SW:   state_d = MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:           state_d = JUMP;
                    default: begin
                        state_d    = HALT;
                        decode_bad = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: if (bus.mem_ready) state_d = WB_MEM;
                    else if (timeout)  state_d = HALT;
            MEM_WR: if (bus.mem_ready) state_d = FETCH;
                    else if (timeout)  state_d = HALT;
            EXEC_R:                  state_d = WB_R;
            EXEC_I:                  state_d = WB_I;
            WB_MEM, WB_R, WB_I:      state_d = FETCH;
            BRANCH, JUMP:            state_d = FETCH;
            HALT:                    state_d = HALT;
            default:                 state_d = HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            wait_q    <= 8'd0;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counter restarts on any state change, so each memory state begins at 0.
            if (state_d != state_q || bus.mem_ready) wait_q <= 8'd0;
            else if (wait_state)                     wait_q <= wait_q + 8'd1;
            if (state_q == DECODE) op_q <= bus.opcode;
            if (decode_bad && state_q == DECODE) illegal_q <= 1'b1;
            if (timeout) bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE:   bus.alu_src_b = 2'b11;
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            WB_R: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            WB_I:     bus.reg_write = 1'b1;
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.pc_write  = (op_q == OP_BEQ) ? bus.zero : ~bus.zero;
            end
            JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.state      = state_q;
    assign bus.halted     = (state_q == HALT);
    assign bus.illegal_op = illegal_q;
    assign bus.bus_error  = bus_err_q;
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle control FSM for the MIPS CPU. It sequences one shared memory port, the register file, the ALU and the PC through fetch, decode, execute, memory and write-back phases for the supported opcodes. It sits beside the datapath, takes the instruction-register opcode, the ALU zero flag and the memory ready handshake, and drives every datapath select and enable.

## Interface
- MEM_WAIT_LIMIT, 15: maximum consecutive cycles `mem_ready` may stay low in a memory state before the block halts with a bus error (1..255).
- clk  in  1  rising-edge system clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current read/write this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target
- ir_write  out  1  instruction register load enable
- iord  out  1  memory address source: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination register: 0 rt, 1 rd
- mem_to_reg  out  1  write-back data: 0 ALUOut, 1 MDR
- alu_src_a  out  1  ALU A: 0 PC, 1 rs
- alu_src_b  out  2  ALU B: 00 rt, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
- alu_op  out  2  00 add, 01 subtract, 10 funct-decoded
- state  out  4  current state encoding (debug)
- halted  out  1  high while in HALT
- illegal_op  out  1  sticky: unsupported opcode decoded
- bus_error  out  1  sticky: memory wait timeout

## Operation
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, WB_MEM 4, MEM_WR 5, EXEC_R 6, WB_R 7, EXEC_I 8, WB_I 9, BRANCH 10, JUMP 11, HALT 15.
- All outputs not listed for a state are 0. Outputs are decoded from the registered state, plus the gating on `mem_ready`/`zero` stated below.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. ir_write=pc_write=mem_ready, with pc_src=00. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Latches opcode into an internal register. Next state by opcode:
  - 000000 → EXEC_R
  - 001000 → EXEC_I
  - 100011 or 101011 → MEM_ADDR
  - 000100 or 000101 → BRANCH
  - 000010 → JUMP
  - any other opcode → HALT, and sets illegal_op.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw (uses the latched opcode).
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then goes to WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEM_WR: mem_write=1, iord=1. Waits for mem_ready, then goes to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to WB_R (reg_write=1, reg_dst=1), then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to WB_I (reg_write=1, reg_dst=0), then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. pc_write=zero for beq, ~zero for bne (latched opcode). Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- HALT: all strobes and enables 0. Left only by reset.
- Wait counter (8-bit), used only in FETCH, MEM_RD and MEM_WR:
  - clears on entry to each of these states and whenever mem_ready=1;
  - increments on each cycle in the state with mem_ready=0;
  - if mem_ready=0 and count==MEM_WAIT_LIMIT, next state is HALT and bus_error is set;
  - mem_ready=1 in that same cycle wins: normal advance, no error.
- illegal_op and bus_error clear only on reset.

## Timing
- Reset (async assert, sync behaviour after deassert): state=FETCH, wait counter 0, latched opcode 0, illegal_op=bus_error=halted=0. During reset, outputs therefore show FETCH decode: mem_read=1, alu_src_b=01, all else 0.
- Reset asserted mid-instruction aborts it immediately. No partial write completes after rst_n falls.
- Cycles per instruction with zero memory wait (mem_ready high in the first cycle of each memory state):
  - R-type, addi, sw: 4
  - lw: 5
  - beq, bne, j: 3
- Each wait cycle adds 1.
- PC and IR load on the same edge that leaves FETCH.
- Register file write occurs on the edge leaving WB_*. Memory write completes on the edge where mem_ready=1 in MEM_WR.

## Test plan
- Reset, then addi (001000) with mem_ready tied 1: states 0→1→8→9→0. reg_write=1 only in state 9. pc_write/ir_write high exactly 1 cycle in FETCH.
- lw, with mem_ready low 3 cycles in MEM_RD: states 0,1,2,3,3,3,3,4,0 (9 cycles). mem_to_reg=1 and reg_write=1 only in WB_MEM.
- beq with zero=1 → pc_write=1, pc_src=01 in BRANCH. bne with zero=1 → pc_write=0. Both take 3 cycles.
- opcode 111111 in DECODE → HALT next cycle; illegal_op=1, halted=1, all strobes 0. Holds for 100 cycles until rst_n low.
- MEM_WAIT_LIMIT=15, mem_ready held 0 in FETCH → HALT after 16 FETCH cycles, bus_error=1. Repeat with mem_ready=1 on cycle 16 → DECODE, no error.
- Assert rst_n low during MEM_WR → state=FETCH asynchronously, mem_write=0 at once. Next instruction fetches normally after release.
